// File: rtl/axi_pmod_gpio.sv
`default_nettype none
// ============================================================================
//  Module      : axi_pmod_gpio
//  Description : AXI4 slave GPIO with parametrised PMOD channels, input
//                synchronisers, sticky W1C rising-edge capture and level irq.
//  Revision    : 1.0 - initial parametrised register file
// ============================================================================
module axi_pmod_gpio #(
    parameter int NUM_CHANNELS  = 2,
    parameter int CHANNEL_WIDTH = 8,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 1,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  s_axi_awvalid,
    output logic                                  s_axi_awready,
    input  logic [ADDR_WIDTH-1:0]                 s_axi_awaddr,
    input  logic [ID_WIDTH-1:0]                   s_axi_awid,
    input  logic                                  s_axi_wvalid,
    output logic                                  s_axi_wready,
    input  logic [DATA_WIDTH-1:0]                 s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]               s_axi_wstrb,
    input  logic                                  s_axi_wlast,
    output logic                                  s_axi_bvalid,
    input  logic                                  s_axi_bready,
    output logic [ID_WIDTH-1:0]                   s_axi_bid,
    output logic [1:0]                            s_axi_bresp,
    input  logic                                  s_axi_arvalid,
    output logic                                  s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]                 s_axi_araddr,
    input  logic [ID_WIDTH-1:0]                   s_axi_arid,
    output logic                                  s_axi_rvalid,
    input  logic                                  s_axi_rready,
    output logic [ID_WIDTH-1:0]                   s_axi_rid,
    output logic [DATA_WIDTH-1:0]                 s_axi_rdata,
    output logic [1:0]                            s_axi_rresp,
    output logic                                  s_axi_rlast,
    input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] gpio_in,
    output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] gpio_out,
    output logic                                  irq
);

    localparam int                    c_TOTAL_W     = NUM_CHANNELS * CHANNEL_WIDTH;
    localparam int                    c_STRB_W      = DATA_WIDTH / 8;
    localparam logic [9:0]            c_ID_IDX      = 10'(NUM_CHANNELS * 4);
    localparam logic [DATA_WIDTH-1:0] c_ID_VALUE    =
        DATA_WIDTH'(32'h4750_0000 | (NUM_CHANNELS << 8) | CHANNEL_WIDTH);
    localparam logic [1:0]            c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]            c_RESP_SLVERR = 2'b10;
    localparam logic [1:0]            c_REG_OUT     = 2'd0;
    localparam logic [1:0]            c_REG_IN      = 2'd1;
    localparam logic [1:0]            c_REG_RISE    = 2'd2;
    localparam logic [1:0]            c_REG_IRQ_EN  = 2'd3;

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    w_state_t                   r_wstate;
    w_state_t                   w_wstate_nxt;
    logic                       r_awready;
    logic                       r_wready;
    logic                       r_bvalid;
    logic [1:0]                 r_bresp;
    logic [ID_WIDTH-1:0]        r_bid;
    logic [9:0]                 r_wr_idx;
    logic [ID_WIDTH-1:0]        r_wid;
    logic [CHANNEL_WIDTH-1:0]   r_wval;
    logic [c_STRB_W-1:0]        r_wstrb;
    logic                       w_do_write;
    logic                       w_b_done;
    logic [7:0]                 w_wr_ch;
    logic [1:0]                 w_wr_reg;
    logic                       w_wr_in_ch;
    logic                       w_wr_ok;
    logic [CHANNEL_WIDTH-1:0]   w_wbits;

    assign w_wr_ch    = r_wr_idx[9:2];
    assign w_wr_reg   = r_wr_idx[1:0];
    assign w_wr_in_ch = (w_wr_ch < 8'(NUM_CHANNELS));
    assign w_wr_ok    = w_wr_in_ch || (r_wr_idx == c_ID_IDX);

    for (genvar i = 0; i < CHANNEL_WIDTH; i++) begin : g_wbits
        assign w_wbits[i] = r_wstrb[i/8];
    end

    always_ff @(posedge clk) begin
        if (rst) r_wstate <= W_IDLE;
        else     r_wstate <= w_wstate_nxt;
    end

    // Both readies low in W_IDLE means AW and W have each been latched.
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_do_write   = 1'b0;
        w_b_done     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (!r_awready && !r_wready) begin
                    w_do_write   = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_b_done     = 1'b1;
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
            r_bid     <= '0;
            r_wr_idx  <= '0;
            r_wid     <= '0;
            r_wval    <= '0;
            r_wstrb   <= '0;
        end else begin
            if (s_axi_awvalid && r_awready) begin
                r_awready <= 1'b0;
                r_wr_idx  <= s_axi_awaddr[11:2];
                r_wid     <= s_axi_awid;
            end
            if (s_axi_wvalid && r_wready) begin
                r_wready <= 1'b0;
                r_wval   <= s_axi_wdata[CHANNEL_WIDTH-1:0];
                r_wstrb  <= s_axi_wstrb;
            end
            if (w_do_write) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? c_RESP_OKAY : c_RESP_SLVERR;
                r_bid    <= r_wid;
            end
            if (w_b_done) begin
                r_bvalid  <= 1'b0;
                r_awready <= 1'b1;
                r_wready  <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    r_state_t                   r_rstate;
    r_state_t                   w_rstate_nxt;
    logic                       r_rvalid;
    logic [DATA_WIDTH-1:0]      r_rdata;
    logic [1:0]                 r_rresp;
    logic [ID_WIDTH-1:0]        r_rid;
    logic [9:0]                 r_rd_idx;
    logic [ID_WIDTH-1:0]        r_arid;
    logic                       w_arready;
    logic                       w_ar_hs;
    logic                       w_r_load;
    logic [7:0]                 w_rd_ch;
    logic [1:0]                 w_rd_reg;
    logic [DATA_WIDTH-1:0]      w_rd_data;
    logic                       w_rd_ok;

    // Accept a new address in the same cycle the previous beat drains,
    // sustaining one read every two cycles.
    assign w_arready = (r_rstate == R_IDLE) && (!r_rvalid || s_axi_rready);
    assign w_ar_hs   = s_axi_arvalid && w_arready;
    assign w_rd_ch   = r_rd_idx[9:2];
    assign w_rd_reg  = r_rd_idx[1:0];

    always_ff @(posedge clk) begin
        if (rst) r_rstate <= R_IDLE;
        else     r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_r_load     = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (w_ar_hs) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                w_r_load     = 1'b1;
                w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= c_RESP_OKAY;
            r_rid    <= '0;
            r_rd_idx <= '0;
            r_arid   <= '0;
        end else begin
            if (w_ar_hs) begin
                r_rd_idx <= s_axi_araddr[11:2];
                r_arid   <= s_axi_arid;
            end
            if (r_rvalid && s_axi_rready) begin
                r_rvalid <= 1'b0;
            end
            if (w_r_load) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_ok ? c_RESP_OKAY : c_RESP_SLVERR;
                r_rid    <= r_arid;
            end
        end
    end

    // ------------------------------------------------------------------
    // GPIO register file and input path
    // ------------------------------------------------------------------
    logic [c_TOTAL_W-1:0] r_out;
    logic [c_TOTAL_W-1:0] r_rise;
    logic [c_TOTAL_W-1:0] r_irq_en;
    logic                 r_irq;
    logic [c_TOTAL_W-1:0] r_sync [SYNC_STAGES];
    logic [c_TOTAL_W-1:0] r_hist;
    logic [c_TOTAL_W-1:0] w_sync_q;
    logic [c_TOTAL_W-1:0] w_edge;
    logic [c_TOTAL_W-1:0] w_w1c;

    assign w_sync_q = r_sync[SYNC_STAGES-1];
    assign w_edge   = w_sync_q & ~r_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_hist <= '0;
        end else begin
            r_sync[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_hist <= w_sync_q;
        end
    end

    always_comb begin
        w_w1c = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (w_do_write && (w_wr_ch == 8'(c)) && (w_wr_reg == c_REG_RISE))
                w_w1c[c*CHANNEL_WIDTH +: CHANNEL_WIDTH] = r_wval & w_wbits;
        end
    end

    // A new edge in the clearing cycle survives: the set term is OR-ed last.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out    <= '0;
            r_rise   <= '0;
            r_irq_en <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_rise <= (r_rise & ~w_w1c) | w_edge;
            r_irq  <= |(r_rise & r_irq_en);
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (w_do_write && (w_wr_ch == 8'(c))) begin
                    if (w_wr_reg == c_REG_OUT)
                        r_out[c*CHANNEL_WIDTH +: CHANNEL_WIDTH] <=
                            (r_out[c*CHANNEL_WIDTH +: CHANNEL_WIDTH] & ~w_wbits) |
                            (r_wval & w_wbits);
                    if (w_wr_reg == c_REG_IRQ_EN)
                        r_irq_en[c*CHANNEL_WIDTH +: CHANNEL_WIDTH] <=
                            (r_irq_en[c*CHANNEL_WIDTH +: CHANNEL_WIDTH] & ~w_wbits) |
                            (r_wval & w_wbits);
                end
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_ok   = 1'b0;
        if (r_rd_idx == c_ID_IDX) begin
            w_rd_data = c_ID_VALUE;
            w_rd_ok   = 1'b1;
        end
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (w_rd_ch == 8'(c)) begin
                w_rd_ok = 1'b1;
                case (w_rd_reg)
                    c_REG_OUT:    w_rd_data[CHANNEL_WIDTH-1:0] = r_out[c*CHANNEL_WIDTH +: CHANNEL_WIDTH];
                    c_REG_IN:     w_rd_data[CHANNEL_WIDTH-1:0] = w_sync_q[c*CHANNEL_WIDTH +: CHANNEL_WIDTH];
                    c_REG_RISE:   w_rd_data[CHANNEL_WIDTH-1:0] = r_rise[c*CHANNEL_WIDTH +: CHANNEL_WIDTH];
                    c_REG_IRQ_EN: w_rd_data[CHANNEL_WIDTH-1:0] = r_irq_en[c*CHANNEL_WIDTH +: CHANNEL_WIDTH];
                    default:      w_rd_data = '0;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_bid     = r_bid;
    assign s_axi_arready = w_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rlast   = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rid     = r_rid;
    assign gpio_out      = r_out;
    assign irq           = r_irq;

    // Address bits outside [11:2], upper data bits and wlast carry no meaning here.
    logic w_unused;
    assign w_unused = &{1'b0, s_axi_wlast, s_axi_awaddr, s_axi_araddr, s_axi_wdata};

endmodule
`default_nettype wire

// File: doc/axi_pmod_gpio.md
Name: axi_pmod_gpio

Overview:
- AXI4 slave GPIO block for the Arty A7 design. Sits behind the JTAG-to-AXI master on the PLL clock domain.
- Drives NUM_CHANNELS PMOD output ports and samples NUM_CHANNELS PMOD input ports through synchroniser stages.
- Captures rising edges on inputs into sticky, write-1-to-clear registers and raises a level interrupt.
- Supersedes the fixed ja/jb/jc/jd wiring with a channel-count and width parametrised register file.

Parameters:
- NUM_CHANNELS, 2, number of PMOD in/out channel pairs (1..16)
- CHANNEL_WIDTH, 8, bits per channel (1..DATA_WIDTH)
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width (32 only)
- ID_WIDTH, 1, AXI ID width
- SYNC_STAGES, 2, input synchroniser depth (>=2)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_axi_awvalid/awready  in/out  1  write address handshake
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awid  in  ID_WIDTH  write ID
- s_axi_wvalid/wready  in/out  1  write data handshake
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  DATA_WIDTH/8  byte strobes
- s_axi_wlast  in  1  ignored; every beat is treated as single
- s_axi_bvalid/bready  out/in  1  write response handshake
- s_axi_bid  out  ID_WIDTH  echoes awid
- s_axi_bresp  out  2  OKAY=00, SLVERR=10
- s_axi_arvalid/arready  in/out  1  read address handshake
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_arid  in  ID_WIDTH  read ID
- s_axi_rvalid/rready  out/in  1  read data handshake
- s_axi_rid  out  ID_WIDTH  echoes arid
- s_axi_rdata  out  DATA_WIDTH  read data
- s_axi_rresp  out  2  OKAY/SLVERR
- s_axi_rlast  out  1  equals rvalid
- gpio_in  in  NUM_CHANNELS*CHANNEL_WIDTH  channel c occupies bits [c*CHANNEL_WIDTH +: CHANNEL_WIDTH]
- gpio_out  out  NUM_CHANNELS*CHANNEL_WIDTH  registered outputs
- irq  out  1  registered; OR over channels of |(RISE & IRQ_EN)

Behaviour:
- Register map, decoded on addr[11:2]; addr[1:0] and bits above 11 are ignored.
  - Channel c base = c*0x10.
  - +0x0 OUT (RW)
  - +0x4 IN (RO, synchronised)
  - +0x8 RISE (sticky, W1C)
  - +0xC IRQ_EN (RW)
  - NUM_CHANNELS*0x10: ID (RO) = 0x4750_0000 | NUM_CHANNELS<<8 | CHANNEL_WIDTH.
  - Any other address: SLVERR, no side effect, rdata = 0.
  - Bits above CHANNEL_WIDTH read as 0; writes to them are ignored.
- Reset:
  - awready=1, wready=1, arready=1.
  - bvalid=0, rvalid=0, rlast=0, bresp=rresp=00, bid=rid=0, rdata=0.
  - gpio_out=0, irq=0.
  - OUT, RISE, IRQ_EN and all synchroniser/edge flops cleared.
  - Reset mid-transaction drops any pending AW, W, B or R; the master must reissue.
- Write channel FSM, states W_IDLE and W_RESP:
  - AW and W are accepted independently. Each ready deasserts after its own handshake until the response completes.
  - When both are latched, the write is performed in the next cycle: the register updates and bvalid rises in that same cycle.
  - bvalid is held with bid/bresp stable until bready. On the bvalid&bready cycle, awready and wready reassert.
  - Write strobes: byte lane i is updated only if wstrb[i]=1.
  - RO targets (IN, ID) return OKAY with no effect.
- Read channel FSM, states R_IDLE and R_DATA:
  - arready=1 in R_IDLE. On the arvalid&arready cycle, address and ID are latched and arready drops.
  - Next cycle: rdata/rresp/rid are registered, rvalid=rlast=1, and all are held stable until rready.
  - Minimum read latency is 2 cycles from the AR handshake to the R handshake.
- Read and write in the same cycle to the same register: the read returns the pre-write value.
- Input path: SYNC_STAGES flop chain, then a one-flop history. A rising edge is sync & ~hist.
- RISE update per bit: RISE <= (RISE & ~w1c) | edge. Set wins over a simultaneous clear.
- gpio_out reflects OUT with 1 cycle latency from the write; irq is registered, 1 cycle after RISE/IRQ_EN change.
- Back-to-back transactions: the write path sustains one write per 3 cycles with bready held high; the read path sustains one read per 2 cycles with rready held high.

Test Plan:
- Reset then read ID at 0x20 (NUM_CHANNELS=2, CHANNEL_WIDTH=8) -> rdata=0x4750_0208, rresp=00, rid echoes arid=1.
- Write 0x0000_00A5 to 0x10 with wstrb=0xF, W presented 3 cycles before AW -> single bvalid with bresp=00; gpio_out[15:8]=0xA5, gpio_out[7:0]=0x00; a write with wstrb=0x0 leaves 0xA5.
- Hold gpio_in[0]=1 from 0 -> IN at 0x04 reads 0x01 no earlier than SYNC_STAGES+1 cycles later; RISE at 0x08 reads 0x01; write IRQ_EN 0x0C=0x01 -> irq=1; write 0x01 to 0x08 -> RISE=0, irq=0 the next cycle.
- W1C on RISE in the same cycle as a new edge on the same bit -> RISE bit remains 1.
- Read 0x40 and write 0x44 -> rresp=10 with rdata=0, bresp=10; no register changes.
- Assert rst while bvalid=1 and bready=0 -> bvalid=0 the next cycle, gpio_out=0, awready=wready=arready=1.
